// File: rtl/puf_link_pkg.sv
// Shared types and framing constants for the UART <-> PUF byte link.
package puf_link_pkg;

    localparam logic [7:0] HDR_REQ = 8'hA5;
    localparam logic [7:0] HDR_RSP = 8'h5A;

    typedef enum logic [2:0] {
        StIdle,
        StRxChal,
        StPufReq,
        StPufWait,
        StTxByte,
        StTxHold,
        StTxWait
    } link_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/link_timeout.sv
// Loadable down-counter; expired_o is high once the count has run down to zero.
module link_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/uart_puf_link.sv
// Framing engine: collects a challenge frame from UART bytes, runs one PUF evaluation and
// streams the framed response back through the UART transmitter.
module uart_puf_link
    import puf_link_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned CHAL_BYTES     = 8,
    parameter int unsigned RESP_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic                            rx_valid,
    output logic                            rx_enable,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            tx_enable,
    input  logic                            tx_busy,
    output logic [DATA_BITS*CHAL_BYTES-1:0] puf_challenge,
    output logic                            puf_start,
    input  logic                            puf_done,
    input  logic [DATA_BITS*RESP_BYTES-1:0] puf_response,
    output logic [7:0]                      err_count
);

    localparam int unsigned IdxW   = $clog2(max_u(CHAL_BYTES, RESP_BYTES) + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    // Reloaded value gives exactly TIMEOUT_CYCLES idle clocks before expiry.
    localparam logic [TimerW-1:0] TimeoutReload = TimerW'(TIMEOUT_CYCLES - 1);

    link_state_t                     state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [DATA_BITS*CHAL_BYTES-1:0] shadow_q, shadow_d;
    logic [DATA_BITS*CHAL_BYTES-1:0] chal_q, chal_d;
    logic [DATA_BITS*RESP_BYTES-1:0] resp_q, resp_d;
    logic [7:0]                      err_q, err_d;
    logic [DATA_BITS-1:0]            tx_byte;
    logic                            to_load, to_expired;

    link_timeout #(
        .Width (TimerW)
    ) u_timeout (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .load_i       (to_load),
        .load_value_i (TimeoutReload),
        .en_i         (state_q == StRxChal),
        .expired_o    (to_expired)
    );

    // Byte 0 of the reply is the header; byte k is response lane k-1.
    always_comb begin
        tx_byte = HDR_RSP;
        for (int unsigned i = 0; i < RESP_BYTES; i++) begin
            if (idx_q == IdxW'(i + 1)) begin
                tx_byte = resp_q[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        chal_d    = chal_q;
        resp_d    = resp_q;
        err_d     = err_q;
        to_load   = 1'b0;
        rx_enable = 1'b0;
        tx_enable = 1'b0;
        puf_start = 1'b0;
        data_out  = '0;

        case (state_q)
            StIdle: begin
                rx_enable = 1'b1;
                if (rx_valid && (data_in == HDR_REQ)) begin
                    state_d = StRxChal;
                    idx_d   = '0;
                    to_load = 1'b1;
                end
            end
            StRxChal: begin
                rx_enable = 1'b1;
                if (rx_valid) begin
                    to_load = 1'b1;
                    for (int unsigned i = 0; i < CHAL_BYTES; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            shadow_d[i*DATA_BITS +: DATA_BITS] = data_in;
                        end
                    end
                    if (idx_q == IdxW'(CHAL_BYTES - 1)) begin
                        // Publish on the way into PufReq so the challenge is valid with puf_start.
                        chal_d  = shadow_d;
                        state_d = StPufReq;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else if (to_expired) begin
                    state_d = StIdle;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            StPufReq: begin
                puf_start = 1'b1;
                state_d   = StPufWait;
            end
            StPufWait: begin
                if (puf_done) begin
                    resp_d  = puf_response;
                    idx_d   = '0;
                    state_d = StTxByte;
                end
            end
            StTxByte: begin
                if (!tx_busy) begin
                    tx_enable = 1'b1;
                    data_out  = tx_byte;
                    state_d   = StTxHold;
                end
            end
            StTxHold: begin
                state_d = StTxWait;
            end
            StTxWait: begin
                if (!tx_busy) begin
                    if (idx_q == IdxW'(RESP_BYTES)) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StTxByte;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            shadow_q <= '0;
            chal_q   <= '0;
            resp_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            chal_q   <= chal_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
        end
    end

    assign puf_challenge = chal_q;
    assign err_count     = err_q;

endmodule
